cozy_blit: RTL and testbench

- Bus-initiator block-move/fill engine. It drives the cozy 16-bit memory port (addr, write data, bwe, read data) from the master side.
- Used by the terminal to scroll and clear the text buffer without CPU copy loops.
- Sits behind the memory arbiter: it requests the bus and drives it only while granted.
- Copies or fills whole 16-bit words only.

---
 rtl/cozy_blit_pkg.sv | 24 ++
 rtl/cozy_blit_ptr.sv | 34 +++
 rtl/cozy_blit.sv | 173 +++++++++++++++++
 tb/tb_cozy_blit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cozy_blit_pkg.sv
// cozy_blit_pkg: shared definitions for the cozy block-move/fill engine.
//   - blit_state_e : FSM state encoding (idle, read, write, finish)
//   - ModeCopy/ModeFill, DirUp/DirDown : command field encodings
//   - BweNone/BweWord : byte-write enable codes, shared with the arbiter and
//     the CPU bus decode so all initiators agree on the word-write encoding
package cozy_blit_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2,
    StFin  = 2'd3
  } blit_state_e;

  localparam logic ModeCopy = 1'b0;
  localparam logic ModeFill = 1'b1;

  localparam logic DirUp   = 1'b0;
  localparam logic DirDown = 1'b1;

  localparam logic [1:0] BweNone = 2'b00;
  localparam logic [1:0] BweWord = 2'b11;

endpackage

// File: rtl/cozy_blit_ptr.sv
// cozy_blit_ptr: loadable 16-bit word pointer with a +/-2 byte step.
//   clk, rst_n : clock, asynchronous active-low reset (clears the pointer)
//   load       : load load_val (bit 0 forced to 0); has priority over en
//   load_val   : byte address to load
//   en         : advance one word this cycle
//   dir        : DirUp steps +2, DirDown steps -2 (wraps modulo 2^16)
//   ptr        : current byte address, bit 0 always 0
module cozy_blit_ptr
  import cozy_blit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        en,
  input  logic        dir,
  output logic [15:0] ptr
);

  logic [15:0] ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 16'h0000;
    end else if (load) begin
      ptr_q <= load_val & 16'hFFFE;
    end else if (en) begin
      ptr_q <= (dir == DirDown) ? ptr_q - 16'd2 : ptr_q + 16'd2;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/cozy_blit.sv
// cozy_blit: bus-initiator block copy / fill engine on the cozy 16-bit port.
//   Command side : start, mode, dir, src, dst, len, fill_val (sampled on start
//                  in idle only); busy, done status.
//   Memory side  : mem_req to the arbiter, mem_gnt grant; mem_addr, mem_wdata,
//                  mem_bwe driven as master; mem_rdata returns one cycle after
//                  a granted read address.
// Copy moves one word per RD/WR pair; fill writes one word per granted cycle.
module cozy_blit
  import cozy_blit_pkg::*;
#(
  parameter int unsigned LEN_BITS = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  input  logic                dir,
  input  logic [15:0]         src,
  input  logic [15:0]         dst,
  input  logic [LEN_BITS-1:0] len,
  input  logic [15:0]         fill_val,
  output logic                busy,
  output logic                done,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic [15:0]         mem_addr,
  output logic [15:0]         mem_wdata,
  output logic [1:0]          mem_bwe,
  input  logic [15:0]         mem_rdata
);

  blit_state_e         state_q, state_d;
  logic                mode_q, mode_d;
  logic                dir_q, dir_d;
  logic [15:0]         fill_q, fill_d;
  logic [LEN_BITS-1:0] count_q, count_d;
  logic [15:0]         hold_q, hold_d;
  logic                fresh_q, fresh_d;

  logic        ptr_load;
  logic        src_en, dst_en;
  logic [15:0] src_ptr, dst_ptr;

  cozy_blit_ptr u_src_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ptr_load),
    .load_val (src),
    .en       (src_en),
    .dir      (dir_q),
    .ptr      (src_ptr)
  );

  cozy_blit_ptr u_dst_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ptr_load),
    .load_val (dst),
    .en       (dst_en),
    .dir      (dir_q),
    .ptr      (dst_ptr)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    dir_d    = dir_q;
    fill_d   = fill_q;
    count_d  = count_q;
    hold_d   = hold_q;
    fresh_d  = fresh_q;
    ptr_load = 1'b0;
    src_en   = 1'b0;
    dst_en   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          ptr_load = 1'b1;
          mode_d   = mode;
          dir_d    = dir;
          fill_d   = fill_val;
          count_d  = len;
          if (len == '0) begin
            state_d = StFin;
          end else if (mode == ModeFill) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end

      StRd: begin
        if (mem_gnt) begin
          state_d = StWr;
          fresh_d = 1'b1;
        end
      end

      StWr: begin
        // Capture read data on the first WR cycle so it survives lost grants.
        if (mode_q == ModeCopy) begin
          if (fresh_q) begin
            hold_d = mem_rdata;
          end
          fresh_d = 1'b0;
        end
        if (mem_gnt) begin
          dst_en  = 1'b1;
          src_en  = (mode_q == ModeCopy);
          count_d = count_q - LEN_BITS'(1);
          if (count_q == LEN_BITS'(1)) begin
            state_d = StFin;
          end else if (mode_q == ModeCopy) begin
            state_d = StRd;
          end else begin
            state_d = StWr;
          end
        end
      end

      StFin: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= ModeCopy;
      dir_q   <= DirUp;
      fill_q  <= 16'h0000;
      count_q <= '0;
      hold_q  <= 16'h0000;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      hold_q  <= hold_d;
      fresh_q <= fresh_d;
    end
  end

  always_comb begin
    busy      = (state_q == StRd) || (state_q == StWr);
    done      = (state_q == StFin);
    mem_req   = busy;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    mem_bwe   = BweNone;
    if (state_q == StRd) begin
      mem_addr = src_ptr;
    end else if (state_q == StWr) begin
      mem_addr = dst_ptr;
      if (mode_q == ModeFill) begin
        mem_wdata = fill_q;
      end else begin
        mem_wdata = fresh_q ? mem_rdata : hold_q;
      end
      mem_bwe = mem_gnt ? BweWord : BweNone;
    end
  end

endmodule

// File: tb/tb_cozy_blit.sv
// tb_cozy_blit: randomized self-checking bench for cozy_blit. A word memory
// answers the bus (CPU reads a random address whenever the blitter is not
// granted); each command is predicted by a sequential word-by-word model.
module tb_cozy_blit;

  localparam int LenBits = 12;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               mode;
  logic               dir;
  logic [15:0]        src;
  logic [15:0]        dst;
  logic [LenBits-1:0] len;
  logic [15:0]        fill_val;
  logic               busy;
  logic               done;
  logic               mem_req;
  logic               mem_gnt;
  logic [15:0]        mem_addr;
  logic [15:0]        mem_wdata;
  logic [1:0]         mem_bwe;
  logic [15:0]        mem_rdata;

  always #5 clk = ~clk;

  cozy_blit #(.LEN_BITS(LenBits)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .dir       (dir),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .fill_val  (fill_val),
    .busy      (busy),
    .done      (done),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_bwe   (mem_bwe),
    .mem_rdata (mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory, bus monitor and preload port.
  logic [15:0] mem     [32768];
  logic [15:0] ref_mem [32768];
  bit          mem_init = 1'b0;
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'h0;
  logic [15:0] pre_data = 16'h0;
  logic [15:0] cpu_addr = 16'h0;
  logic [15:0] wr_log [$];
  int          cyc = 0, done_cnt = 0, done_cyc = 0, busy_cyc = 0;
  int          bad_bwe = 0, bad_req = 0;

  always @(posedge clk) begin
    logic [15:0] bus_addr;
    cyc++;
    bus_addr = mem_gnt ? mem_addr : cpu_addr;
    if (!mem_init) begin
      for (int i = 0; i < 32768; i++) mem[i] <= 16'(i * 40503) ^ 16'h5a5a;
      mem_init <= 1'b1;
    end else begin
      if (pre_we) mem[pre_addr[15:1]] <= pre_data;
      if (mem_bwe == 2'b11) mem[mem_addr[15:1]] <= mem_wdata;
    end
    mem_rdata <= mem[bus_addr[15:1]];
    if (mem_bwe == 2'b11) wr_log.push_back(mem_addr);
    if (mem_bwe != 2'b00 && !mem_gnt) bad_bwe++;
    if (mem_bwe == 2'b01 || mem_bwe == 2'b10) bad_bwe++;
    if (mem_req !== busy || mem_addr[0] || (busy && done)) bad_req++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cyc++;
  end

  // Grant and CPU-address driver: scripted grants first, then random.
  int   gnt_pct = 100;
  bit   gnt_script [$];

  always @(negedge clk) begin
    if (gnt_script.size() > 0) mem_gnt = gnt_script.pop_front();
    else mem_gnt = ($urandom_range(99) < gnt_pct);
    cpu_addr = 16'($urandom);
  end

  task automatic preload(input logic [15:0] a, input logic [15:0] v);
    @(negedge clk);
    pre_we = 1'b1;
    pre_addr = a;
    pre_data = v;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic run_cmd(input string nm, input bit m, input bit d, input logic [15:0] s,
                         input logic [15:0] dd, input int l, input logic [15:0] fv,
                         input bit interfere);
    logic [15:0] sp, dp, w;
    logic [15:0] exp_addr [$];
    int d0, w0, b0, bb0, br0, c0, lat, bad;
    bit full;
    @(negedge clk);
    full = (gnt_pct == 100) && (gnt_script.size() == 0);
    for (int i = 0; i < 32768; i++) ref_mem[i] = mem[i];
    sp = s & 16'hFFFE;
    dp = dd & 16'hFFFE;
    for (int i = 0; i < l; i++) begin
      w = m ? fv : ref_mem[sp[15:1]];
      ref_mem[dp[15:1]] = w;
      exp_addr.push_back(dp);
      sp = d ? sp - 16'd2 : sp + 16'd2;
      dp = d ? dp - 16'd2 : dp + 16'd2;
    end
    d0 = done_cnt; w0 = wr_log.size(); b0 = busy_cyc;
    bb0 = bad_bwe; br0 = bad_req; c0 = cyc;
    start = 1'b1; mode = m; dir = d; src = s; dst = dd; len = LenBits'(l); fill_val = fv;
    @(negedge clk);
    start = 1'b0;
    mode = 1'($urandom); dir = 1'($urandom); src = 16'($urandom); dst = 16'($urandom);
    len = LenBits'($urandom); fill_val = 16'($urandom);
    if (interfere) begin
      @(negedge clk);
      start = 1'b1; mode = 1'b1; dst = dd ^ 16'h0800; len = LenBits'(7);
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < 20000 && done_cnt == d0; k++) @(negedge clk);
    check({nm, ".timeout"}, 32'(done_cnt != d0), 32'd1);
    repeat (3) @(negedge clk);
    check({nm, ".done_cnt"}, done_cnt - d0, 1);
    check({nm, ".wr_cnt"}, wr_log.size() - w0, l);
    bad = 0;
    for (int i = 0; i < l && w0 + i < wr_log.size(); i++)
      if (wr_log[w0 + i] !== exp_addr[i]) bad++;
    check({nm, ".wr_addr"}, bad, 0);
    bad = 0;
    for (int i = 0; i < 32768; i++) if (mem[i] !== ref_mem[i]) bad++;
    check({nm, ".mem"}, bad, 0);
    check({nm, ".bwe_nognt"}, bad_bwe - bb0, 0);
    check({nm, ".req_busy"}, bad_req - br0, 0);
    if (full) begin
      lat = (l == 0) ? 1 : (m ? l + 1 : 2 * l + 1);
      check({nm, ".busy_cyc"}, busy_cyc - b0, (l == 0) ? 0 : (m ? l : 2 * l));
      check({nm, ".done_lat"}, done_cyc - c0, lat + 1);
    end
  endtask

  initial begin
    int d0, k;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; dir = 1'b0; src = '0; dst = '0;
    len = '0; fill_val = '0;
    repeat (3) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.req", mem_req, 0);
    check("rst.addr", mem_addr, 0);
    check("rst.wdata", mem_wdata, 0);
    check("rst.bwe", mem_bwe, 0);
    rst_n = 1'b1;

    run_cmd("fill3", 1'b1, 1'b0, 16'h0, 16'h1000, 3, 16'h2020, 1'b0);

    preload(16'h0100, 16'h1111); preload(16'h0102, 16'h2222); preload(16'h0104, 16'h3333);
    run_cmd("copy_up", 1'b0, 1'b0, 16'h0100, 16'h0102, 3, 16'h0, 1'b0);
    preload(16'h0100, 16'h1111); preload(16'h0102, 16'h2222); preload(16'h0104, 16'h3333);
    run_cmd("copy_dn", 1'b0, 1'b1, 16'h0104, 16'h0106, 3, 16'h0, 1'b0);
    check("copy_dn.w0106", mem[16'h0106 >> 1], 16'h3333);
    check("copy_dn.w0102", mem[16'h0102 >> 1], 16'h1111);

    gnt_script = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    run_cmd("gnt_loss", 1'b0, 1'b0, 16'h0300, 16'h0400, 2, 16'h0, 1'b0);

    run_cmd("len0", 1'b0, 1'b0, 16'h0500, 16'h0600, 0, 16'h0, 1'b0);
    run_cmd("wrap", 1'b1, 1'b0, 16'h0, 16'hFFFE, 2, 16'hBEEF, 1'b0);
    run_cmd("odd_src", 1'b0, 1'b0, 16'h0201, 16'h0701, 2, 16'h0, 1'b0);
    run_cmd("busy_start", 1'b1, 1'b0, 16'h0, 16'h2000, 5, 16'hA5A5, 1'b1);

    // Asynchronous reset while a copy is in WR.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; dir = 1'b0; src = 16'h3000; dst = 16'h3100;
    len = LenBits'(6);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (mem_bwe != 2'b11 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("arst.reach_wr", mem_bwe, 2'b11);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("arst.bwe", mem_bwe, 0);
    check("arst.busy", busy, 0);
    check("arst.req", mem_req, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("arst.no_done", done_cnt - d0, 0);
    run_cmd("post_rst", 1'b1, 1'b0, 16'h0, 16'h3200, 1, 16'h7777, 1'b0);

    for (int t = 0; t < 25; t++) begin
      gnt_pct = ($urandom_range(3) == 0) ? 100 : int'($urandom_range(100, 40));
      run_cmd("rand", 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
              int'($urandom_range(40)), 16'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
